alu_nibble_seq: RTL and testbench



---
 rtl/alu_nibble_seq.sv | 114 +++++++++++
 tb/tb_alu_nibble_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: nibble-serial sequencer around an external ALU4 slice (optional abort: ALU_NIBBLE_SEQ_ABORT_EN)
module alu_nibble_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic [4*WORDS-1:0] a,
    input  logic [4*WORDS-1:0] b,
    input  logic [3:0]         S,
    input  logic               M,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] result,
    output logic               co,
    output logic               V,
    output logic               Z,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [3:0]         alu_S,
    output logic               alu_M,
    output logic               alu_cin,
    input  logic [3:0]         alu_do,
    input  logic               alu_co,
    input  logic               alu_V,
    input  logic               alu_Z
);
    localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [4*WORDS-1:0] a_reg, b_reg, part, part_nx;
    logic               cin_reg, carry, zacc, last, abrt;

`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    assign abrt = abort;
`else
    assign abrt = 1'b0;
`endif

    assign last    = cnt == LAST;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign alu_a   = a_reg[{cnt, 2'b00} +: 4];
    assign alu_b   = b_reg[{cnt, 2'b00} +: 4];
    assign alu_cin = cnt == '0 ? cin_reg : carry;

    // partial result with the current slice output merged into nibble cnt
    always_comb begin
        part_nx = part;
        part_nx[{cnt, 2'b00} +: 4] = alu_do;
    end

    // next state: abort wins everywhere (no effect in IDLE beyond blocking start)
    always_comb begin
        state_nx = abrt ? IDLE : state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // operand latch, nibble stepping and word-level flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            alu_S   <= '0;
            alu_M   <= 1'b0;
            cin_reg <= 1'b0;
            cnt     <= '0;
            carry   <= 1'b0;
            zacc    <= 1'b0;
            part    <= '0;
            result  <= '0;
            co      <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
        end else if (!abrt) begin
            if (state == IDLE && start) begin
                a_reg   <= a;
                b_reg   <= b;
                alu_S   <= S;
                alu_M   <= M;
                cin_reg <= cin;
                cnt     <= '0;
                carry   <= 1'b0;
                zacc    <= 1'b1;
                part    <= '0;
            end
            if (state == RUN) begin
                part  <= part_nx;
                carry <= alu_co;
                zacc  <= zacc & alu_Z;
                cnt   <= last ? cnt : cnt + 1'b1;
                if (last) begin
                    result <= part_nx;
                    co     <= alu_co;
                    V      <= alu_V;
                    Z      <= zacc & alu_Z;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed self-checking bench with a behavioural ALU4 slice
module tb_alu_nibble_seq;
    localparam int WORDS = 4;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, M = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0, result;
    logic [3:0]  S = '0, alu_a, alu_b, alu_S, alu_do, bb;
    logic        busy, done, co, V, Z, alu_M, alu_cin, alu_co, alu_V, alu_Z;
    logic [4:0]  sum;
    int          n_cmp = 0, n_bad = 0;
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_nibble_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start), .a(a), .b(b), .S(S), .M(M), .cin(cin),
        .busy(busy), .done(done), .result(result), .co(co), .V(V), .Z(Z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_S(alu_S), .alu_M(alu_M), .alu_cin(alu_cin),
        .alu_do(alu_do), .alu_co(alu_co), .alu_V(alu_V), .alu_Z(alu_Z)
    );

    // ALU4 slice: M=1 arithmetic (1001 add, 0110 A+~B+cin), M=0 logic (0110 xor, else pass A)
    always_comb begin
        bb  = alu_S == 4'b0110 ? ~alu_b : alu_b;
        sum = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_cin};
        if (alu_M) begin
            alu_do = sum[3:0];
            alu_co = sum[4];
            alu_V  = (alu_a[3] == bb[3]) && (sum[3] != alu_a[3]);
        end else begin
            alu_do = alu_S == 4'b0110 ? alu_a ^ alu_b : alu_a;
            alu_co = 1'b1;
            alu_V  = 1'b0;
        end
        alu_Z = alu_do == 4'h0;
    end

    // launches one operation; lat = number of falling edges after the accepting edge until done (30 = timeout)
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is, input logic im, input logic ic, output int lat);
        @(negedge clk);
        a = ia; b = ib; S = is; M = im; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, co, V, Z} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, co, V, Z}); end
        n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=0000", result); end
        n_cmp++; if ({alu_a, alu_b, alu_S, alu_M, alu_cin} !== 14'h0) begin n_bad++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_S, alu_M, alu_cin}); end
        rst = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is, input logic im, input logic ic,
                           input logic [15:0] er, input logic eco, input logic ev, input logic ez);
        int lat;
        do_op(ia, ib, is, im, ic, lat);
        n_cmp++; if (lat !== WORDS + 1) begin n_bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, WORDS + 1); end
        n_cmp++; if (result !== er) begin n_bad++; $display("FAIL %s_result got=%h exp=%h", name, result, er); end
        n_cmp++; if ({co, V, Z, busy} !== {eco, ev, ez, 1'b1}) begin n_bad++; $display("FAIL %s_flags co/V/Z/busy got=%b exp=%b", name, {co, V, Z, busy}, {eco, ev, ez, 1'b1}); end
        @(negedge clk);
        n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL %s_done_pulse done/busy got=%b exp=00", name, {done, busy}); end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; S = 4'b1001; M = 1'b1; cin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            a = 16'hFFFF; b = 16'hFFFF;
            start = (i == 2 || i == 5);
            if (done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL b2b_done_count got=%0d exp=1", dones); end
        n_cmp++; if (result !== 16'h2233) begin n_bad++; $display("FAIL b2b_result got=%h exp=2233", result); end
    endtask

    task automatic test_rst_abort;
        int dones = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; S = 4'b1001; M = 1'b1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
`ifdef ALU_NIBBLE_SEQ_ABORT_EN
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_cmp++; if (result !== 16'h2233) begin n_bad++; $display("FAIL abort_result got=%h exp=2233", result); end
`else
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL rst_result got=%h exp=0000", result); end
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    endtask

    initial begin
        test_reset();
        test_op("add", 16'h1234, 16'h0FFF, 4'b1001, 1'b1, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        test_op("sub", 16'h8000, 16'h0001, 4'b0110, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        test_op("zero", 16'h00FF, 16'h00FF, 4'b0110, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        test_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b0, 1'b0, 16'h0FF0, 1'b1, 1'b0, 1'b0);
        test_back_to_back();
        test_rst_abort();
        test_op("after_rst", 16'h8000, 16'h0001, 4'b0110, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
